tremolo_lfo: RTL and testbench

- Parametrised successor to the fixed square-wave tremolo stage in the audio effects chain.
- Applies amplitude modulation to a mono PCM sample stream using an internal phase-accumulator LFO.
- Rate, depth and waveform (square or triangle) are selectable at run time.
- Adds a valid/ready handshake with backpressure, and carries the sample address alongside the audio through a 2-stage pipeline.

---
 rtl/tremolo_lfo_if.sv | 24 ++
 rtl/tremolo_lfo.sv | 79 +++++++
 tb/tb_tremolo_lfo.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tremolo_lfo_if.sv
// rtl/tremolo_lfo_if.sv - sample stream handshake bundle for tremolo_lfo
interface tremolo_lfo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] audio_in;
  logic [ADDR_W-1:0]        address_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] audio_out;
  logic [ADDR_W-1:0]        address_out;

  modport slave (
    input  in_valid, audio_in, address_in, out_ready,
    output in_ready, out_valid, audio_out, address_out
  );

  modport master (
    output in_valid, audio_in, address_in, out_ready,
    input  in_ready, out_valid, audio_out, address_out
  );
endinterface

// File: rtl/tremolo_lfo.sv
// rtl/tremolo_lfo.sv - two-stage tremolo with phase-accumulator LFO and address pass-through
module tremolo_lfo #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [PHASE_W-1:0] rate,
  input  logic [7:0]         depth,
  tremolo_lfo_if.slave       s
);

  logic                     advance;
  logic                     accept;
  logic [PHASE_W-1:0]       phase;
  logic [7:0]               t8;
  logic [15:0]              depth_t8;
  logic [8:0]               gain;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_audio;
  logic [ADDR_W-1:0]        s1_addr;
  logic [8:0]               s1_gain;
  logic signed [DATA_W+9:0] product;

  assign advance    = !s.out_valid || s.out_ready;
  assign s.in_ready = advance;
  assign accept     = s.in_valid && advance;

  // Triangle falls on the second half by inverting the top bits below the MSB.
  always_comb begin
    t8 = 8'h00;
    if (!mode)
      t8 = phase[PHASE_W-1] ? 8'hFF : 8'h00;
    else if (!phase[PHASE_W-1])
      t8 = phase[PHASE_W-2 -: 8];
    else
      t8 = ~phase[PHASE_W-2 -: 8];
  end

  always_comb begin
    depth_t8 = 16'(depth) * 16'(t8);
    gain     = en ? (9'd256 - 9'(depth_t8 >> 8)) : 9'd256;
  end

  // Gain is zero-extended so the signed product never flips sign at g = 256.
  assign product = s1_audio * $signed({1'b0, s1_gain});

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= '0;
      s1_valid      <= 1'b0;
      s1_audio      <= '0;
      s1_addr       <= '0;
      s1_gain       <= 9'd256;
      s.out_valid   <= 1'b0;
      s.audio_out   <= '0;
      s.address_out <= '0;
    end else begin
      if (!en)
        phase <= '0;
      else if (accept)
        phase <= phase + rate;

      if (advance) begin
        s1_valid      <= accept;
        s1_audio      <= s.audio_in;
        s1_addr       <= s.address_in;
        s1_gain       <= gain;
        s.out_valid   <= s1_valid;
        s.audio_out   <= DATA_W'(product >>> 8);
        s.address_out <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_tremolo_lfo.sv
// tb/tb_tremolo_lfo.sv - scoreboard bench for tremolo_lfo
module tb_tremolo_lfo;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [PW-1:0] rate;
  logic [7:0]    depth;

  tremolo_lfo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  tremolo_lfo #(.DATA_W(DW), .ADDR_W(AW), .PHASE_W(PW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .rate  (rate),
    .depth (depth),
    .s     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int mphase = 0;
  logic [DW-1:0] exp_audio[$];
  logic [AW-1:0] exp_addr[$];

  function automatic logic [DW-1:0] model_out(input logic signed [DW-1:0] a, input int ph,
                                               input bit e, input bit m, input int dep);
    int t8;
    int g;
    longint p;
    longint q;
    t8 = 0;
    if (!e) g = 256;
    else begin
      if (!m) t8 = (ph >= 32768) ? 255 : 0;
      else begin
        t8 = (ph % 32768) / 128;
        if (ph >= 32768) t8 = 255 - t8;
      end
      g = 256 - (dep * t8) / 256;
    end
    p = longint'(a) * g;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return q[DW-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    checks++; if (bus.audio_out !== '0) begin fails++; $display("FAIL reset_audio got=%h required=0", bus.audio_out); end
    checks++; if (bus.address_out !== '0) begin fails++; $display("FAIL reset_addr got=%h required=0", bus.address_out); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] smp[100];
    logic [AW-1:0] adr[100];
    logic [DW-1:0] ea;
    logic [AW-1:0] eb;
    int sent = 0, cyc = 0, acc_cyc = -1, out_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      smp[i] = 16'($urandom);
      adr[i] = $urandom;
    end
    smp[10] = 16'h8000;
    smp[20] = 16'h7FFF;
    en = 1'b0; bus.out_ready = 1'b1;
    while ((sent < 100 || exp_audio.size() != 0) && cyc < 400) begin
      bus.in_valid   = (sent < 100);
      bus.audio_in   = smp[sent % 100];
      bus.address_in = adr[sent % 100];
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (out_cyc < 0) out_cyc = cyc;
        checks++;
        if (exp_audio.size() == 0) begin fails++; $display("FAIL bypass_extra got=%h required=none", bus.audio_out); end
        else begin
          ea = exp_audio.pop_front(); eb = exp_addr.pop_front();
          if (bus.audio_out !== ea || bus.address_out !== eb) begin
            fails++; $display("FAIL bypass_out got=%h/%h required=%h/%h", bus.audio_out, bus.address_out, ea, eb);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        exp_audio.push_back(smp[sent]); exp_addr.push_back(adr[sent]); sent++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_audio.size() != 0 || sent != 100) begin fails++; $display("FAIL bypass_timeout got=%0d sent required=100", sent); end
    checks++; if (out_cyc - acc_cyc != 2) begin fails++; $display("FAIL bypass_latency got=%0d required=2", out_cyc - acc_cyc); end
    checks++; if (dut.phase !== '0) begin fails++; $display("FAIL bypass_phase got=%h required=0", dut.phase); end
  endtask

  task automatic test_square();
    logic [DW-1:0] ea;
    logic [AW-1:0] eb;
    int sent = 0, cyc = 0;
    en = 1'b1; mode = 1'b0; depth = 8'd255; rate = 16'h4000; bus.out_ready = 1'b1;
    while ((sent < 8 || exp_audio.size() != 0) && cyc < 100) begin
      bus.in_valid = (sent < 8); bus.audio_in = 16'd16384; bus.address_in = 32'h100 + 32'(sent);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_audio.size() == 0) begin fails++; $display("FAIL square_extra got=%0d required=none", $signed(bus.audio_out)); end
        else begin
          ea = exp_audio.pop_front(); eb = exp_addr.pop_front();
          if (bus.audio_out !== ea || bus.address_out !== eb) begin
            fails++; $display("FAIL square_out got=%0d/%h required=%0d/%h", $signed(bus.audio_out), bus.address_out, $signed(ea), eb);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_audio.push_back((sent % 4 < 2) ? 16'd16384 : 16'd128);
        exp_addr.push_back(32'h100 + 32'(sent)); sent++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_audio.size() != 0 || sent != 8) begin fails++; $display("FAIL square_timeout got=%0d sent required=8", sent); end
  endtask

  task automatic test_triangle();
    logic [DW-1:0] ins[4]  = '{16'd1000, 16'd1000, 16'd1000, 16'hFC18};
    logic [DW-1:0] outs[4] = '{16'd1000, 16'd750, 16'd503, 16'hFD0E};
    logic [DW-1:0] ea;
    logic [AW-1:0] eb;
    int sent = 0, cyc = 0;
    en = 1'b1; mode = 1'b1; depth = 8'd128; rate = 16'h4000; bus.out_ready = 1'b1;
    while ((sent < 4 || exp_audio.size() != 0) && cyc < 60) begin
      bus.in_valid = (sent < 4); bus.audio_in = ins[sent % 4]; bus.address_in = 32'h200 + 32'(sent);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_audio.size() == 0) begin fails++; $display("FAIL tri_extra got=%0d required=none", $signed(bus.audio_out)); end
        else begin
          ea = exp_audio.pop_front(); eb = exp_addr.pop_front();
          if (bus.audio_out !== ea || bus.address_out !== eb) begin
            fails++; $display("FAIL tri_out got=%0d/%h required=%0d/%h", $signed(bus.audio_out), bus.address_out, $signed(ea), eb);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_audio.push_back(outs[sent]); exp_addr.push_back(32'h200 + 32'(sent)); sent++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_audio.size() != 0 || sent != 4) begin fails++; $display("FAIL tri_timeout got=%0d sent required=4", sent); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] smp[3] = '{16'h1111, 16'h8000, 16'h7FFF};
    logic [DW-1:0] held0, held1, ea;
    logic [AW-1:0] eb;
    int sent = 0, cyc = 0;
    held0 = '0; held1 = '0;
    en = 1'b0; bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (sent < 3); bus.audio_in = smp[sent % 3]; bus.address_in = 32'hB0 + 32'(sent);
      @(negedge clk);
      if (c == 3) held0 = bus.audio_out;
      if (c == 5) held1 = bus.audio_out;
      if (bus.in_valid && bus.in_ready) begin
        exp_audio.push_back(smp[sent]); exp_addr.push_back(32'hB0 + 32'(sent)); sent++;
      end
      @(posedge clk); #1;
    end
    checks++; if (sent != 2) begin fails++; $display("FAIL bp_accepted got=%0d required=2", sent); end
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b required=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid got=%b required=1", bus.out_valid); end
    checks++; if (held0 !== 16'h1111 || held1 !== 16'h1111) begin fails++; $display("FAIL bp_hold got=%h,%h required=1111", held0, held1); end
    bus.out_ready = 1'b1;
    while ((sent < 3 || exp_audio.size() != 0) && cyc < 50) begin
      bus.in_valid = (sent < 3); bus.audio_in = smp[sent % 3]; bus.address_in = 32'hB0 + 32'(sent);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_audio.size() == 0) begin fails++; $display("FAIL bp_extra got=%h required=none", bus.audio_out); end
        else begin
          ea = exp_audio.pop_front(); eb = exp_addr.pop_front();
          if (bus.audio_out !== ea || bus.address_out !== eb) begin
            fails++; $display("FAIL bp_out got=%h/%h required=%h/%h", bus.audio_out, bus.address_out, ea, eb);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_audio.push_back(smp[sent]); exp_addr.push_back(32'hB0 + 32'(sent)); sent++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_audio.size() != 0 || sent != 3) begin fails++; $display("FAIL bp_timeout got=%0d sent required=3", sent); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_duplicate got=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_en();
    logic [DW-1:0] ea, a;
    logic [AW-1:0] eb;
    int sent, cyc, total;
    en = 1'b1; mode = 1'b0; depth = 8'd200; rate = 16'hFFFF; bus.out_ready = 1'b1; mphase = 0;
    for (int part = 0; part < 2; part++) begin
      sent = 0; cyc = 0; total = (part == 0) ? 6 : 3;
      while ((sent < total || exp_audio.size() != 0) && cyc < 60) begin
        a = 16'($urandom);
        bus.in_valid = (sent < total); bus.audio_in = a; bus.address_in = 32'hC00 + 32'(part * 16 + sent);
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_audio.size() == 0) begin fails++; $display("FAIL wrap_extra got=%h required=none", bus.audio_out); end
          else begin
            ea = exp_audio.pop_front(); eb = exp_addr.pop_front();
            if (bus.audio_out !== ea || bus.address_out !== eb) begin
              fails++; $display("FAIL wrap_out got=%h/%h required=%h/%h", bus.audio_out, bus.address_out, ea, eb);
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          checks++;
          if (dut.phase !== 16'(mphase)) begin fails++; $display("FAIL wrap_phase got=%h required=%h", dut.phase, 16'(mphase)); end
          exp_audio.push_back(model_out(a, mphase, 1'b1, 1'b0, 200));
          exp_addr.push_back(32'hC00 + 32'(part * 16 + sent));
          mphase = (mphase + 65535) % 65536; sent++;
        end
        @(posedge clk); #1; cyc++;
      end
      bus.in_valid = 1'b0;
      checks++; if (exp_audio.size() != 0 || sent != total) begin fails++; $display("FAIL wrap_timeout got=%0d sent required=%0d", sent, total); end
      if (part == 0) begin
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        checks++; if (dut.phase !== '0) begin fails++; $display("FAIL en_drop_phase got=%h required=0", dut.phase); end
        mphase = 0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] ea;
    logic [AW-1:0] eb;
    int sent = 0, cyc = 0;
    en = 1'b1; mode = 1'b0; depth = 8'd255; rate = 16'h4000; bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.audio_in = 16'(1000 * (i + 1)); bus.address_in = 32'hD0 + 32'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || dut.s1_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_full got=%b%b required=11", bus.out_valid, dut.s1_valid); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got=%b required=0", bus.out_valid); end
    checks++; if (bus.audio_out !== '0 || bus.address_out !== '0) begin fails++; $display("FAIL rst_mid_data got=%h/%h required=0/0", bus.audio_out, bus.address_out); end
    checks++; if (dut.s1_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_s1 got=%b required=0", dut.s1_valid); end
    rst = 1'b0;
    while ((sent < 4 || exp_audio.size() != 0) && cyc < 60) begin
      bus.in_valid = (sent < 4); bus.audio_in = 16'd16384; bus.address_in = 32'hE0 + 32'(sent);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_audio.size() == 0) begin fails++; $display("FAIL rst_resume_extra got=%0d required=none", $signed(bus.audio_out)); end
        else begin
          ea = exp_audio.pop_front(); eb = exp_addr.pop_front();
          if (bus.audio_out !== ea || bus.address_out !== eb) begin
            fails++; $display("FAIL rst_resume_out got=%0d/%h required=%0d/%h", $signed(bus.audio_out), bus.address_out, $signed(ea), eb);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_audio.push_back((sent < 2) ? 16'd16384 : 16'd128);
        exp_addr.push_back(32'hE0 + 32'(sent)); sent++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_audio.size() != 0 || sent != 4) begin fails++; $display("FAIL rst_resume_timeout got=%0d sent required=4", sent); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; rate = '0; depth = '0;
    bus.in_valid = 1'b0; bus.audio_in = '0; bus.address_in = '0; bus.out_ready = 1'b1;
    test_reset();
    test_bypass();
    test_square();
    test_triangle();
    test_backpressure();
    test_wrap_en();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
